// File: rtl/dbg_view_pkg.sv
// Shared types and view-stepping helpers for the debug display view sequencer.
// The mask helpers are used by the VIEW_MASK_EN build; the default build passes an all-ones mask.
package dbg_view_pkg;

  typedef enum logic [2:0] {
    V_INSTR, V_RD1, V_RD2, V_RESULT, V_ALUSRC, V_IMMEXT, V_PCTARGET, V_PCNEXT
  } view_sel_t;

  typedef enum logic [1:0] {MANUAL, AUTO, HOLD} seq_state_t;

  localparam logic [7:0] ALL_VIEWS = 8'hFF;

  // Next enabled view in the given direction; returns cur when no other view is enabled.
  function automatic logic [2:0] step_view(input logic [2:0] cur, input logic [7:0] mask,
                                           input logic up);
    logic [2:0] cand;
    logic [2:0] res;
    logic       found;
    cand  = cur;
    res   = cur;
    found = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cand = up ? cand + 3'd1 : cand - 3'd1;
      if (!found && mask[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [2:0] lowest_view(input logic [7:0] mask);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) res = 3'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Active-low pushbutton conditioner: 2-FF synchronizer, stable-level debounce counter,
// and a one-cycle pulse on each accepted press (release produces nothing).
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, sync_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn_n;
      sync_q  <= meta_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any synced sample matching the accepted level restarts the stability count.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
        press_d = ~sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/debug_view_sequencer.sv
// Debug display view select: manual stepping from two buttons or timed auto-scroll.
// Optional feature macro VIEW_MASK_EN restricts stepping to views enabled in VIEW_MASK.
module debug_view_sequencer
  import dbg_view_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned DWELL_CYCLES    = 50_000_000,
  parameter logic [7:0]  VIEW_MASK       = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next_n,
  input  logic       btn_prev_n,
  input  logic       auto_en,
  input  logic       pause,
  output logic [2:0] selm,
  output logic       view_change,
  output logic       auto_active
);

`ifdef VIEW_MASK_EN
  localparam logic [7:0] EFF_MASK = VIEW_MASK;
`else
  localparam logic [7:0] EFF_MASK = ALL_VIEWS | (VIEW_MASK & 8'h00);
`endif

  localparam view_sel_t RESET_VIEW = view_sel_t'(lowest_view(EFF_MASK));
  localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  logic       next_p, prev_p;
  logic [1:0] sw_meta_q, sw_sync_q;
  logic       auto_s, pause_s;

  seq_state_t    state_q, state_d;
  view_sel_t     selm_q, selm_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          vc_q;
  logic          btn_step, dwell_term;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_next_n),
    .press (next_p)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_prev_n),
    .press (prev_p)
  );

  // Switches are level controls, so synchronizing is enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_q <= 2'b00;
      sw_sync_q <= 2'b00;
    end else begin
      sw_meta_q <= {pause, auto_en};
      sw_sync_q <= sw_meta_q;
    end
  end

  assign auto_s  = sw_sync_q[0];
  assign pause_s = sw_sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MANUAL;
      selm_q  <= RESET_VIEW;
      dwell_q <= '0;
      vc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      selm_q  <= selm_d;
      dwell_q <= dwell_d;
      vc_q    <= (selm_d != selm_q);
    end
  end

  // Simultaneous next/prev cancel; a lone button step takes priority over the dwell timeout.
  always_comb begin
    state_d    = state_q;
    selm_d     = selm_q;
    dwell_d    = dwell_q;
    btn_step   = next_p ^ prev_p;
    dwell_term = (state_q == AUTO) && (dwell_q == DWELL_LAST);

    if (!auto_s)      state_d = MANUAL;
    else if (pause_s) state_d = HOLD;
    else              state_d = AUTO;

    if (btn_step)        selm_d = view_sel_t'(step_view(selm_q, EFF_MASK, next_p));
    else if (dwell_term) selm_d = view_sel_t'(step_view(selm_q, EFF_MASK, 1'b1));

    // Dwell rests at zero in MANUAL so leaving it always starts a fresh dwell.
    case (state_q)
      MANUAL:  dwell_d = '0;
      AUTO:    dwell_d = (btn_step || dwell_term) ? '0 : dwell_q + 1'b1;
      default: dwell_d = dwell_q;
    endcase
  end

  assign selm        = selm_q;
  assign view_change = vc_q;
  assign auto_active = (state_q != MANUAL);

endmodule

// File: tb/tb_debug_view_sequencer.sv
// Randomized + directed bench for debug_view_sequencer against a window-based reference model.
// Build with VIEW_MASK_EN defined to exercise the masked view set 8'b1000_1001.
module tb_debug_view_sequencer;

  localparam int DEB = 4;
  localparam int DW  = 10;
`ifdef VIEW_MASK_EN
  localparam logic [7:0] M_MASK = 8'b1000_1001;
`else
  localparam logic [7:0] M_MASK = 8'hFF;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bn = 1'b1, bp = 1'b1, ae = 1'b0, ps = 1'b0;
  logic [2:0] selm;
  logic       view_change, auto_active;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [7:0] mmask = M_MASK;

  // Reference model state
  int m_selm, m_mode, m_dwell;
  bit m_vc, pend_n, pend_p, acc_n, acc_p;
  bit dn_q[$], dp_q[$], da_q[$], dps_q[$];
  bit hist_n[$], hist_p[$];

  debug_view_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .DWELL_CYCLES    (DW),
    .VIEW_MASK       (8'b1000_1001)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .btn_next_n  (bn),
    .btn_prev_n  (bp),
    .auto_en     (ae),
    .pause       (ps),
    .selm        (selm),
    .view_change (view_change),
    .auto_active (auto_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_step(input int cur, input int dir);
    for (int k = 1; k < 8; k++) begin
      int c;
      c = (cur + dir * k + 8) % 8;
      if (mmask[c]) return c;
    end
    return cur;
  endfunction

  function automatic bit all_eq(input bit q[$], input bit v);
    foreach (q[i]) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_selm = 0;
    for (int i = 7; i >= 0; i--) if (mmask[i]) m_selm = i;
    m_mode = 0; m_dwell = 0; m_vc = 0;
    pend_n = 0; pend_p = 0; acc_n = 1; acc_p = 1;
    dn_q = '{1'b1, 1'b1}; dp_q = '{1'b1, 1'b1};
    da_q = '{1'b0, 1'b0}; dps_q = '{1'b0, 1'b0};
    hist_n.delete(); hist_p.delete();
  endtask

  // One clock edge of the reference: a button is accepted when the last DEB synced
  // samples all disagree with the accepted level; its press acts on the following edge.
  task automatic model_edge();
    bit sn, sp, sa, sps, btn, term;
    int old, new_mode;
    dn_q.push_back(bn);  sn  = dn_q.pop_front();
    dp_q.push_back(bp);  sp  = dp_q.pop_front();
    da_q.push_back(ae);  sa  = da_q.pop_front();
    dps_q.push_back(ps); sps = dps_q.pop_front();
    new_mode = sa ? (sps ? 2 : 1) : 0;

    old  = m_selm;
    btn  = (pend_n != pend_p);
    term = (m_mode == 1) && (m_dwell == DW - 1);
    if (btn)       m_selm = m_step(m_selm, pend_n ? 1 : -1);
    else if (term) m_selm = m_step(m_selm, 1);
    if (m_mode == 1) m_dwell = (btn || term) ? 0 : m_dwell + 1;
    if (m_mode == 0 && new_mode != 0) m_dwell = 0;
    m_vc = (m_selm != old);

    hist_n.push_back(sn); if (hist_n.size() > DEB) void'(hist_n.pop_front());
    hist_p.push_back(sp); if (hist_p.size() > DEB) void'(hist_p.pop_front());
    pend_n = 0; pend_p = 0;
    if (hist_n.size() == DEB && all_eq(hist_n, sn) && sn != acc_n) begin
      acc_n = sn; pend_n = !sn;
    end
    if (hist_p.size() == DEB && all_eq(hist_p, sp) && sp != acc_p) begin
      acc_p = sp; pend_p = !sp;
    end
    m_mode = new_mode;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("selm", selm, m_selm);
    chk("view_change", view_change, m_vc);
    chk("auto_active", auto_active, m_mode != 0);
    if (view_change) $display("t=%0t view -> %0d (auto_active=%0d)", $time, selm, auto_active);
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_selm", selm, m_selm);
    chk("rst_view_change", view_change, 0);
    chk("rst_auto_active", auto_active, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic press(input bit nxt, input bit prv, input int len, input int gap);
    if (nxt) bn = 1'b0;
    if (prv) bp = 1'b0;
    repeat (len) tick();
    bn = 1'b1; bp = 1'b1;
    repeat (gap) tick();
  endtask

  initial begin
    int lat;
    int guard;
    #1;
    do_reset();
    repeat (6) tick();

    // Short glitch is ignored; a real press steps once after sync + debounce + 1 edges.
    press(1, 0, 3, 10);
    lat = 0;
    bn = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (view_change && lat == 0) lat = k;
      if (k == 8) bn = 1'b1;
    end
    chk("press_latency", lat, 7);

    // Wrap in both directions.
    do_reset();
    repeat (4) tick();
    press(0, 1, 8, 6);
    press(1, 0, 8, 6);
    press(1, 0, 8, 6);
    press(0, 1, 8, 6);

    // Simultaneous presses in MANUAL.
    press(1, 1, 8, 8);

    // Auto-scroll with pause/resume, then simultaneous presses while scrolling.
    ae = 1'b1;
    repeat (25) tick();
    ps = 1'b1;
    repeat (15) tick();
    ps = 1'b0;
    repeat (20) tick();
    press(1, 1, 8, 8);
    press(1, 0, 8, 12);

    // Reset mid-scroll once selm reaches 5 (or bounded wait).
    guard = 0;
    while (selm != 3'd5 && guard < 200) begin
      tick();
      guard++;
    end
    do_reset();
    ae = 1'b0;
    repeat (6) tick();

    // Randomized soak.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0)  bn = ~bn;
      if ($urandom_range(0, 9) == 0)  bp = ~bp;
      if ($urandom_range(0, 79) == 0) ae = ~ae;
      if ($urandom_range(0, 49) == 0) ps = ~ps;
      if ($urandom_range(0, 199) == 0) begin
        bn = 1'b0; bp = 1'b0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
